// File: rtl/inv_roundadd_kbuf.sv
// Inverse AddRoundKey stage: buffers the 11 round keys and
// applies them in reverse round order, one round per cycle.
module inv_roundadd_kbuf #(
   parameter int NR = 10,
   parameter int KW = 128
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          key_wr_en,
   input  logic [3:0]    key_wr_idx,
   input  logic [KW-1:0] key_wr_data,
   input  logic          clear_in,
   input  logic [KW-1:0] data_in,
   input  logic          start_in,
   input  logic [3:0]    round_in,
   output logic [KW-1:0] data_out,
   output logic          ready_out,
   output logic          done_out,
   output logic [3:0]    expect_round,
   output logic          key_err,
   output logic          seq_err
);

   localparam logic [3:0] LAST = 4'(NR);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state;
   state_t        state_nx;
   logic [3:0]    exp_nx;
   logic [KW-1:0] keys [NR+1];
   logic [NR:0]   vld;
   logic          accept;
   logic          wr_ok;
   logic          wr_bad;
   logic          last_rnd;

   always_comb begin
      state_nx = state;
      exp_nx   = expect_round;
      accept   = 1'b0;
      last_rnd = 1'b0;
      wr_ok    = key_wr_en && (key_wr_idx <= LAST) && !clear_in;
      wr_bad   = key_wr_en && (key_wr_idx > LAST) && !clear_in;
      if (clear_in) begin
         state_nx = IDLE;
         exp_nx   = LAST;
      end else if (start_in && (round_in == expect_round)
                   && vld[expect_round]) begin
         accept = 1'b1;
         unique case (1'b1)
            (round_in == LAST): begin
               state_nx = RUN;
               exp_nx   = LAST - 4'd1;
            end
            (round_in == 4'd0): begin
               state_nx = IDLE;
               exp_nx   = LAST;
               last_rnd = 1'b1;
            end
            default: exp_nx = expect_round - 4'd1;
         endcase
      end
   end

   // Key storage is not reset; the valid mask gates every use.
   always_ff @(posedge clk) begin
      if (wr_ok) keys[key_wr_idx] <= key_wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         expect_round <= LAST;
         data_out     <= '0;
         ready_out    <= 1'b0;
         done_out     <= 1'b0;
         key_err      <= 1'b0;
         seq_err      <= 1'b0;
         vld          <= '0;
      end else begin
         state        <= state_nx;
         expect_round <= exp_nx;
         ready_out    <= accept;
         done_out     <= last_rnd;
         if (accept) data_out <= data_in ^ keys[expect_round];
         if (clear_in) begin
            vld     <= '0;
            key_err <= 1'b0;
            seq_err <= 1'b0;
         end else begin
            if (wr_ok) vld[key_wr_idx] <= 1'b1;
            if (wr_bad) key_err <= 1'b1;
            if (start_in && !accept) seq_err <= 1'b1;
         end
      end
   end

endmodule
